// File: rtl/aes_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// aes_ctrl_pkg
// Shared definitions for the AES round-scheduler control slice:
//   - state_t   : scheduler FSM states
//   - NR_DEF    : default number of cipher rounds
//   - KS_CYCLES_DEF : default key-expansion hold time in cycles
//   - RIDX_W    : width of the round-index bus
// -----------------------------------------------------------------------------
package aes_ctrl_pkg;

  localparam int NR_DEF        = 10;
  localparam int KS_CYCLES_DEF = 12;
  localparam int RIDX_W        = 4;

  typedef enum logic [2:0] {
    ST_NOKEY = 3'd0,
    ST_KRST  = 3'd1,
    ST_KEXP  = 3'd2,
    ST_IDLE  = 3'd3,
    ST_RUN   = 3'd4,
    ST_RESP  = 3'd5
  } state_t;

endpackage

// File: rtl/aes_round_cnt.sv
// -----------------------------------------------------------------------------
// aes_round_cnt
// Clear/enable up-counter with a terminal-count flag. Shared by the scheduler
// for timing the key expansion and for stepping through the cipher rounds.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   i_clr      : synchronous clear (wins over i_en)
//   i_en       : count enable
//   i_tc_val   : terminal value to compare against
//   o_count    : current count
//   o_tc       : high while o_count == i_tc_val
// -----------------------------------------------------------------------------
module aes_round_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_tc_val,
  output logic [W-1:0] o_count,
  output logic         o_tc
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;
  assign o_tc    = (r_count == i_tc_val);

endmodule

// File: rtl/aes_round_sched.sv
// -----------------------------------------------------------------------------
// aes_round_sched
// Control scheduler for an iterative AES core. Sequences the key-expansion
// engine (ks_start/ks_ed) and the round datapath (dp_load/round_en) and runs a
// valid/ready handshake on both the request and response sides.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   key_load, key_mode   : new-key pulse and its direction (1 = decrypt)
//   req_valid/req_mode/req_ready    : block request handshake
//   resp_valid/resp_ready           : block result handshake
//   ks_start, ks_ed, key_ready      : key-schedule control and status
//   dp_load, round_en, round_idx, final_round : datapath sequencing
//   busy                 : high while expanding, running or responding
// All outputs except round_idx's source counter are registered from the
// next-state decode, so they change only on clock edges (or on reset).
// -----------------------------------------------------------------------------
module aes_round_sched
  import aes_ctrl_pkg::*;
#(
  parameter int NR        = NR_DEF,
  parameter int KS_CYCLES = KS_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_load,
  input  logic              key_mode,
  input  logic              req_valid,
  input  logic              req_mode,
  output logic              req_ready,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              ks_start,
  output logic              ks_ed,
  output logic              key_ready,
  output logic              dp_load,
  output logic              round_en,
  output logic [RIDX_W-1:0] round_idx,
  output logic              final_round,
  output logic              busy
);

  localparam int CNT_MAX = (NR > KS_CYCLES) ? NR : KS_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t              r_state;
  state_t              w_nxt;
  logic                r_pend_key;
  logic                r_pend_req;
  logic                r_ks_ed;
  logic                w_pk_nxt;
  logic                w_pr_nxt;
  logic                w_ed_nxt;
  logic                w_accept;
  logic                w_tc;
  logic                w_cnt_run;
  logic [CNT_W-1:0]    w_cnt;
  logic [CNT_W-1:0]    w_tc_val;

  logic                r_req_ready;
  logic                r_resp_valid;
  logic                r_ks_start;
  logic                r_key_ready;
  logic                r_dp_load;
  logic                r_round_en;
  logic                r_final_round;
  logic [RIDX_W-1:0]   r_round_idx;
  logic                r_busy;

  // A key_load in the same cycle as a request wins: the request is not taken
  // and the requester simply retries once the new keys are ready.
  assign w_accept = req_valid && r_req_ready && !key_load;

  // The counter compares against the last round in RUN and the last
  // expansion cycle in KEXP.
  assign w_tc_val = (r_state == ST_RUN) ? CNT_W'(NR) : CNT_W'(KS_CYCLES - 1);

  // Count only while staying in KEXP or RUN; every other cycle clears it, so
  // each entry into KEXP or RUN starts from zero.
  assign w_cnt_run = ((r_state == ST_KEXP) && !key_load && !w_tc) ||
                     ((r_state == ST_RUN) && !w_tc);

  aes_round_cnt #(
    .W (CNT_W)
  ) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clr    (!w_cnt_run),
    .i_en     (w_cnt_run),
    .i_tc_val (w_tc_val),
    .o_count  (w_cnt),
    .o_tc     (w_tc)
  );

  always_comb begin
    w_nxt    = r_state;
    w_pk_nxt = r_pend_key;
    w_pr_nxt = r_pend_req;
    w_ed_nxt = r_ks_ed;
    if (key_load) begin
      w_ed_nxt = key_mode;
    end
    case (r_state)
      ST_NOKEY: begin
        if (key_load) w_nxt = ST_KRST;
      end
      ST_KRST: begin
        w_nxt = ST_KEXP;
      end
      ST_KEXP: begin
        if (key_load) begin
          w_nxt = ST_KRST;
        end else if (w_tc) begin
          // A request that forced the re-expansion skips IDLE.
          if (r_pend_req) begin
            w_nxt    = ST_RUN;
            w_pr_nxt = 1'b0;
          end else begin
            w_nxt = ST_IDLE;
          end
        end
      end
      ST_IDLE: begin
        if (key_load) begin
          w_nxt = ST_KRST;
        end else if (w_accept) begin
          if (req_mode == r_ks_ed) begin
            w_nxt = ST_RUN;
          end else begin
            w_ed_nxt = req_mode;
            w_pr_nxt = 1'b1;
            w_nxt    = ST_KRST;
          end
        end
      end
      ST_RUN: begin
        // Keys must not change under a running block; defer the reload.
        if (key_load) w_pk_nxt = 1'b1;
        if (w_tc) w_nxt = ST_RESP;
      end
      ST_RESP: begin
        if (key_load) w_pk_nxt = 1'b1;
        if (resp_ready) begin
          if (r_pend_key || key_load) begin
            w_pk_nxt = 1'b0;
            w_nxt    = ST_KRST;
          end else begin
            w_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        w_nxt = ST_NOKEY;
      end
    endcase
    if (w_nxt == ST_KRST) begin
      // The explicit KRST transitions above already cover this; kept so a
      // KRST cycle always re-evaluates the restart condition.
      w_nxt = ST_KRST;
    end
    if (r_state == ST_KRST && key_load) begin
      w_nxt = ST_KRST;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_NOKEY;
      r_pend_key    <= 1'b0;
      r_pend_req    <= 1'b0;
      r_ks_ed       <= 1'b0;
      r_req_ready   <= 1'b0;
      r_resp_valid  <= 1'b0;
      r_ks_start    <= 1'b0;
      r_key_ready   <= 1'b0;
      r_dp_load     <= 1'b0;
      r_round_en    <= 1'b0;
      r_final_round <= 1'b0;
      r_round_idx   <= '0;
      r_busy        <= 1'b0;
    end else begin
      r_state      <= w_nxt;
      r_pend_key   <= w_pk_nxt;
      r_pend_req   <= w_pr_nxt;
      r_ks_ed      <= w_ed_nxt;
      // ks_start stays high from KEXP entry until the next KRST.
      r_ks_start   <= (w_nxt == ST_KEXP) || (w_nxt == ST_IDLE) ||
                      (w_nxt == ST_RUN)  || (w_nxt == ST_RESP);
      // A deferred reload means the expanded keys no longer match ks_ed.
      r_key_ready  <= ((w_nxt == ST_IDLE) || (w_nxt == ST_RUN) ||
                       (w_nxt == ST_RESP)) && !w_pk_nxt;
      r_req_ready  <= (w_nxt == ST_IDLE) && !w_pk_nxt && !w_pr_nxt;
      r_resp_valid <= (w_nxt == ST_RESP);
      r_busy       <= (w_nxt == ST_KRST) || (w_nxt == ST_KEXP) ||
                      (w_nxt == ST_RUN)  || (w_nxt == ST_RESP);
      // First RUN cycle loads the block; later RUN cycles execute rounds.
      r_dp_load     <= (w_nxt == ST_RUN) && (r_state != ST_RUN);
      r_round_en    <= (w_nxt == ST_RUN) && (r_state == ST_RUN);
      r_final_round <= (w_nxt == ST_RUN) && (r_state == ST_RUN) &&
                       (w_cnt == CNT_W'(NR - 1));
      r_round_idx   <= ((w_nxt == ST_RUN) && (r_state == ST_RUN)) ?
                       RIDX_W'(w_cnt + CNT_W'(1)) : '0;
    end
  end

  assign req_ready   = r_req_ready;
  assign resp_valid  = r_resp_valid;
  assign ks_start    = r_ks_start;
  assign ks_ed       = r_ks_ed;
  assign key_ready   = r_key_ready;
  assign dp_load     = r_dp_load;
  assign round_en    = r_round_en;
  assign round_idx   = r_round_idx;
  assign final_round = r_final_round;
  assign busy        = r_busy;

endmodule

// File: tb/tb_aes_round_sched.sv
module tb_aes_round_sched;

  localparam int NR = 10;
  localparam int KS = 12;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_load = 1'b0;
  logic       key_mode = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_mode = 1'b0;
  logic       resp_ready = 1'b0;
  logic       req_ready;
  logic       resp_valid;
  logic       ks_start;
  logic       ks_ed;
  logic       key_ready;
  logic       dp_load;
  logic       round_en;
  logic [3:0] round_idx;
  logic       final_round;
  logic       busy;

  always #5 clk = ~clk;

  aes_round_sched #(.NR(NR), .KS_CYCLES(KS)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_load    (key_load),
    .key_mode    (key_mode),
    .req_valid   (req_valid),
    .req_mode    (req_mode),
    .req_ready   (req_ready),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .ks_start    (ks_start),
    .ks_ed       (ks_ed),
    .key_ready   (key_ready),
    .dp_load     (dp_load),
    .round_en    (round_en),
    .round_idx   (round_idx),
    .final_round (final_round),
    .busy        (busy)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Timeline model: instead of tracking an FSM, remember the cycle at which
  // the latest key expansion started (its KRST cycle) and the cycle at which
  // the current block's dp_load happens; every output follows by arithmetic.
  typedef enum {P_NOKEY, P_KRST, P_KEXP, P_IDLE, P_RUN, P_RESP} ph_t;
  bit m_key;
  bit m_mode;
  bit m_pend_key;
  int m_ks_at;
  int m_run_at;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", nm, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_key      = 1'b0;
    m_mode     = 1'b0;
    m_pend_key = 1'b0;
    m_ks_at    = -100;
    m_run_at   = -1;
  endtask

  function automatic ph_t phase_of(input int c);
    if (!m_key) return P_NOKEY;
    if (c == m_ks_at) return P_KRST;
    if (c < m_ks_at + 1 + KS) return P_KEXP;
    if (m_run_at >= 0 && c >= m_run_at) return (c <= m_run_at + NR) ? P_RUN : P_RESP;
    return P_IDLE;
  endfunction

  task automatic model_edge();
    ph_t p;
    int  n;
    if (!rst_n) begin
      model_reset();
      return;
    end
    p = phase_of(cyc);
    n = cyc + 1;
    if (key_load) begin
      m_mode = key_mode;
      if (p == P_RUN || p == P_RESP) begin
        m_pend_key = 1'b1;
      end else begin
        m_key   = 1'b1;
        m_ks_at = n;
        if (m_run_at >= 0) m_run_at = n + 1 + KS;
      end
    end else if (p == P_IDLE && req_valid) begin
      if (req_mode == m_mode) begin
        m_run_at = n;
      end else begin
        m_mode   = req_mode;
        m_ks_at  = n;
        m_run_at = n + 1 + KS;
      end
    end
    if (p == P_RESP && resp_ready) begin
      m_run_at = -1;
      if (m_pend_key) begin
        m_pend_key = 1'b0;
        m_ks_at    = n;
      end
    end
  endtask

  task automatic compare_all();
    ph_t p;
    int  idx;
    p   = phase_of(cyc);
    idx = (p == P_RUN) ? cyc - m_run_at : 0;
    chk("ks_start",    32'(ks_start),    32'(p == P_KEXP || p == P_IDLE || p == P_RUN || p == P_RESP));
    chk("ks_ed",       32'(ks_ed),       32'(m_mode));
    chk("key_ready",   32'(key_ready),   32'((p == P_IDLE || p == P_RUN || p == P_RESP) && !m_pend_key));
    chk("req_ready",   32'(req_ready),   32'(p == P_IDLE));
    chk("resp_valid",  32'(resp_valid),  32'(p == P_RESP));
    chk("dp_load",     32'(dp_load),     32'(p == P_RUN && idx == 0));
    chk("round_en",    32'(round_en),    32'(p == P_RUN && idx > 0));
    chk("final_round", 32'(final_round), 32'(p == P_RUN && idx == NR));
    chk("round_idx",   32'(round_idx),   32'(idx));
    chk("busy",        32'(busy),        32'(p == P_KRST || p == P_KEXP || p == P_RUN || p == P_RESP));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    compare_all();
  endtask

  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_all_outputs_zero",
        32'({req_ready, resp_valid, ks_start, ks_ed, key_ready, dp_load,
             round_en, round_idx, final_round, busy}), 32'd0);
    compare_all();
    step();
    step();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bit prev_kl;
    model_reset();

    // Reset held.
    step();
    step();
    chk("reset_outputs",
        32'({req_ready, resp_valid, ks_start, ks_ed, key_ready, dp_load,
             round_en, round_idx, final_round, busy}), 32'd0);

    // Key load right on the first edge after reset release.
    @(negedge clk);
    rst_n    = 1'b1;
    key_load = 1'b1;
    key_mode = 1'b0;
    step();
    chk("krst_ks_start", 32'(ks_start), 32'd0);
    chk("krst_busy",     32'(busy),     32'd1);
    key_load = 1'b0;
    for (int k = 2; k <= 13; k++) begin
      step();
      chk("kexp_ks_start",  32'(ks_start),  32'd1);
      chk("kexp_key_ready", 32'(key_ready), 32'd0);
    end
    step();
    chk("key_ready_at_14", 32'(key_ready), 32'd1);
    chk("req_ready_at_14", 32'(req_ready), 32'd1);

    // Encrypt request, matching mode, response taken immediately.
    req_valid  = 1'b1;
    req_mode   = 1'b0;
    resp_ready = 1'b1;
    step();
    chk("enc_dp_load_p1", 32'(dp_load),   32'd1);
    chk("enc_idx_p1",     32'(round_idx), 32'd0);
    req_valid = 1'b0;
    for (int k = 2; k <= 11; k++) begin
      step();
      chk("enc_round_en", 32'(round_en),    32'd1);
      chk("enc_idx",      32'(round_idx),   32'(k - 1));
      chk("enc_final",    32'(final_round), 32'(k == 11));
    end
    step();
    chk("enc_resp_p12", 32'(resp_valid), 32'd1);
    step();
    chk("enc_idle_p13", 32'(req_ready), 32'd1);

    // Mode switch: request decrypt with encrypt keys loaded.
    req_valid = 1'b1;
    req_mode  = 1'b1;
    step();
    chk("sw_ks_ed",    32'(ks_ed),    32'd1);
    chk("sw_ks_start", 32'(ks_start), 32'd0);
    req_valid = 1'b0;
    for (int k = 2; k <= 25; k++) begin
      step();
      if (k <= 24) chk("sw_req_ready_low", 32'(req_ready), 32'd0);
      if (k == 14) chk("sw_dp_load_p14",   32'(dp_load),   32'd1);
      if (k == 25) chk("sw_resp_p25",      32'(resp_valid), 32'd1);
    end
    step();

    // Back-pressured response.
    resp_ready = 1'b0;
    req_valid  = 1'b1;
    req_mode   = 1'b1;
    step();
    req_valid = 1'b0;
    for (int k = 2; k <= 16; k++) begin
      step();
      if (k >= 12) begin
        chk("bp_resp_held",  32'(resp_valid), 32'd1);
        chk("bp_req_ready0", 32'(req_ready),  32'd0);
      end
    end
    resp_ready = 1'b1;
    step();
    chk("bp_resp_done", 32'(resp_valid), 32'd0);
    chk("bp_idle",      32'(req_ready),  32'd1);

    // Reset in the middle of a block at round 5.
    req_valid = 1'b1;
    req_mode  = 1'b1;
    step();
    req_valid = 1'b0;
    for (int k = 2; k <= 6; k++) step();
    chk("mid_idx5", 32'(round_idx), 32'd5);
    async_reset();
    req_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("nokey_req_ready", 32'(req_ready), 32'd0);
      chk("nokey_dp_load",   32'(dp_load),   32'd0);
    end
    req_valid = 1'b0;
    key_load  = 1'b1;
    key_mode  = 1'b1;
    step();
    key_load = 1'b0;
    for (int k = 0; k < 13; k++) step();
    chk("reload_key_ready", 32'(key_ready), 32'd1);

    // Randomized traffic against the timeline model.
    prev_kl = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      key_load   = !prev_kl && ($urandom_range(0, 39) == 0);
      prev_kl    = key_load;
      key_mode   = 1'($urandom_range(0, 1));
      req_valid  = ($urandom_range(0, 1) == 1);
      req_mode   = ($urandom_range(0, 3) == 0) ? ~ks_ed : ks_ed;
      resp_ready = ($urandom_range(0, 2) != 0);
      step();
      if (i % 997 == 996) begin
        key_load  = 1'b0;
        req_valid = 1'b0;
        async_reset();
        prev_kl = 1'b0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
